contador_4b: RTL and testbench

CONTADOR_4B -- requirements
Module: contador_4b

---
 rtl/contador_4b_if.sv | 33 +++
 rtl/contador_4b.sv | 74 +++++++
 tb/tb_contador_4b.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/contador_4b_if.sv
// ---------------------------------------------------------------------------
// contador_4b_if
// Groups the data-side signals of the contador_4b counter so the counter
// and whatever drives it share one bundle. clk and reset stay outside the
// interface as plain module ports.
//
//   enable : count enable, driven by the master
//   count  : current counter value, driven by the counter
//   rco    : ripple-carry-out, driven by the counter
//
// Modports:
//   master : the side that drives enable and observes count/rco
//   slave  : the counter itself
// ---------------------------------------------------------------------------
interface contador_4b_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic [WIDTH-1:0] count;
  logic             rco;

  modport master (
    output enable,
    input  count,
    input  rco
  );

  modport slave (
    input  enable,
    output count,
    output rco
  );
endinterface

// File: rtl/contador_4b.sv
// ---------------------------------------------------------------------------
// contador_4b
// Unsigned WIDTH-bit up-counter with count enable and ripple-carry-out.
// The count wraps from 2^WIDTH-1 to 0 without an idle cycle.
//
// Ports:
//   clk    : rising-edge clock for all state
//   reset  : synchronous active-high reset (clears count and any rco state)
//   bus    : contador_4b_if.slave
//              bus.enable : 1 = advance on next rising edge, 0 = hold
//              bus.count  : current value, straight from a register
//              bus.rco    : ripple-carry-out
//
// Parameter:
//   WIDTH  : counter width in bits, 2..16 (default 4). Must match the WIDTH
//            of the connected interface instance.
//
// Configuration macro:
//   CONTADOR_RCO_REG_EN
//     undefined : rco = enable AND (count == all ones), purely combinational,
//                 so it drops the moment enable drops.
//     defined   : rco is a flip-flop that pulses high for exactly one cycle,
//                 the cycle in which count reads 0 right after a wrap.
//   The count path is the same in both builds.
// ---------------------------------------------------------------------------
module contador_4b #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  contador_4b_if.slave  bus
);

  logic [WIDTH-1:0] countReg;
  logic             atTerminal;

  // Full-width equality against all ones, so rco can never be asserted by a
  // partially decoded pattern while count bits are settling.
  assign atTerminal = (countReg == {WIDTH{1'b1}});

  // Counter register: reset beats enable, enable beats hold. The +1 simply
  // overflows to zero at terminal count, which gives the wrap for free.
  always_ff @(posedge clk) begin
    if (reset) begin
      countReg <= '0;
    end else if (bus.enable) begin
      countReg <= countReg + 1'b1;
    end
  end

  assign bus.count = countReg;

`ifdef CONTADOR_RCO_REG_EN
  logic rcoReg;

  // Registered carry: set on the edge that wraps terminal count to zero,
  // and cleared on every other edge, so it lines up with count == 0 for a
  // single cycle. A reset at terminal count kills the wrap, hence no pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      rcoReg <= 1'b0;
    end else begin
      rcoReg <= bus.enable && atTerminal;
    end
  end

  assign bus.rco = rcoReg;
`else
  // Combinational carry: high only while the counter sits at terminal count
  // and is allowed to advance, so cascaded stages step together.
  assign bus.rco = bus.enable && atTerminal;
`endif

endmodule

// File: tb/tb_contador_4b.sv
// ---------------------------------------------------------------------------
// tb_contador_4b
// Self-checking bench for contador_4b (WIDTH = 4). Every clock edge gets an
// expected {count, rco} pushed to a scoreboard queue when the inputs are
// driven; the entry is popped and compared just after the edge. Builds with
// or without CONTADOR_RCO_REG_EN; the model follows the same macro.
// ---------------------------------------------------------------------------
module tb_contador_4b;

  localparam int WIDTH = 4;
  localparam logic [WIDTH-1:0] MAXV = {WIDTH{1'b1}};

  typedef struct {
    logic [WIDTH-1:0] count;
    logic             rco;
  } expect_t;

  logic clk;
  logic reset;

  contador_4b_if #(.WIDTH(WIDTH)) bus ();

  contador_4b #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  expect_t          scoreboard[$];
  logic [WIDTH-1:0] modelCount;
  logic             modelRco;
  int               checkCount;
  int               errorCount;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed,
               expected, $time);
    end
  endtask

  // Drive one edge worth of inputs, predict the result, then compare it.
  // glitch: pulse reset high briefly between edges, which must be ignored.
  task automatic applyStimulus(input logic rst, input logic en,
                               input logic glitch, input string tag);
    expect_t e;
    expect_t got;
    @(negedge clk);
    reset      = rst;
    bus.enable = en;
    if (rst)     e.count = '0;
    else if (en) e.count = modelCount + 1'b1;
    else         e.count = modelCount;
`ifdef CONTADOR_RCO_REG_EN
    e.rco = !rst && en && (modelCount == MAXV);
`else
    e.rco = en && (e.count == MAXV);
`endif
    scoreboard.push_back(e);
    if (glitch) begin
      #1 reset = 1'b1;
      #1 reset = 1'b0;
    end
    @(posedge clk);
    #1;
    got = scoreboard.pop_front();
    checkOutput({tag, ".count"}, 32'(bus.count), 32'(got.count));
    checkOutput({tag, ".rco"},   32'(bus.rco),   32'(got.rco));
    modelCount = got.count;
    modelRco   = got.rco;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    modelCount = '0;
    modelRco   = 1'b0;
    reset      = 1'b1;
    bus.enable = 1'b0;

    // Two reset edges; the second also has enable high and reset must win.
    applyStimulus(1'b1, 1'b0, 1'b0, "reset0");
    applyStimulus(1'b1, 1'b1, 1'b0, "reset1");

    // Free count through a wrap: 1..15, 0, 1..4.
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 1'b0, "run20");

    // Count to 5, hold 4 edges, then advance to 6.
    applyStimulus(1'b1, 1'b0, 1'b0, "rstA");
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, "to5");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, "hold5");
    applyStimulus(1'b0, 1'b1, 1'b0, "to6");

    // Count to 15, then drop enable between edges: rco must react at once.
    applyStimulus(1'b1, 1'b0, 1'b0, "rstB");
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1, 1'b0, "to15");
    @(negedge clk);
    bus.enable = 1'b0;
    #1;
`ifdef CONTADOR_RCO_REG_EN
    checkOutput("dropEn.rco", 32'(bus.rco), 32'(modelRco));
`else
    checkOutput("dropEn.rco", 32'(bus.rco), 32'(1'b0));
`endif
    checkOutput("dropEn.count", 32'(bus.count), 32'(MAXV));
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, "hold15");

    // Reset together with enable at 9, then next enabled edge gives 1.
    applyStimulus(1'b1, 1'b0, 1'b0, "rstC");
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 1'b0, "to9");
    applyStimulus(1'b1, 1'b1, 1'b0, "rstAt9");
    applyStimulus(1'b0, 1'b1, 1'b0, "after9");

    // Reach terminal count, reset there, and confirm no carry follows.
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b1, 1'b0, "to15b");
    applyStimulus(1'b1, 1'b1, 1'b0, "rstAt15");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, "post15");

    // A reset pulse that spans no rising edge must leave the count alone.
    applyStimulus(1'b0, 1'b1, 1'b1, "glitchEn");
    applyStimulus(1'b0, 1'b0, 1'b1, "glitchHold");
    applyStimulus(1'b0, 1'b1, 1'b0, "afterGlitch");

    $display("Simulation finished: %0d checks, %0d errors", checkCount,
             errorCount);
    $finish;
  end

  // Watchdog so the run always ends even if the stimulus stalls.
  initial begin
    #100000;
    errorCount++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checkCount,
             errorCount);
    $finish;
  end

endmodule
